// File: rtl/car_alarm_ctrl.sv
// rtl/car_alarm_ctrl.sv - car alarm controller: per-door debounce, exit delay, siren timing
// and lights-left-on warning.
module car_alarm_ctrl #(
    parameter int N_DOORS      = 4,
    parameter int DEB_CYCLES   = 4,
    parameter int GRACE_CYCLES = 16,
    parameter int SIREN_CYCLES = 32
) (
    input  logic               sClk,
    input  logic               sRst_n,
    input  logic               sLuz,
    input  logic [N_DOORS-1:0] sPrta,
    input  logic               sIgn,
    input  logic               sArm,
    input  logic               sDisarm,
    output logic               sAlarm,
    output logic               sLightWarn,
    output logic [N_DOORS-1:0] sDoorOpen,
    output logic [1:0]         sState,
    output logic               sArmFail
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int GW = $clog2(GRACE_CYCLES + 1);
    localparam int SW = $clog2(SIREN_CYCLES + 1);

    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [GW-1:0] GRACE_LD = GW'(GRACE_CYCLES);
    localparam logic [SW-1:0] SIREN_LD = SW'(SIREN_CYCLES);

    typedef enum logic [1:0] {
        ST_DISARMED  = 2'b00,
        ST_ARMING    = 2'b01,
        ST_ARMED     = 2'b10,
        ST_TRIGGERED = 2'b11
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [GW-1:0]      r_grace;
    logic [GW-1:0]      w_grace_next;
    logic [SW-1:0]      r_siren;
    logic [SW-1:0]      w_siren_next;
    logic               r_alarm;
    logic               w_alarm_next;
    logic               r_arm_fail;
    logic               w_arm_fail_next;
    logic               r_light_warn;
    logic               r_ign_q;
    logic [N_DOORS-1:0] r_door_open;
    logic [N_DOORS-1:0] r_door_prev;
    logic [N_DOORS-1:0] w_door_next;
    logic [DW-1:0]      r_deb_cnt  [N_DOORS];
    logic [DW-1:0]      w_deb_next [N_DOORS];
    logic               w_door_rise;
    logic               w_ign_rise;
    logic               w_any_rise;

    // A door flips on the edge its mismatch run reaches DEB_CYCLES; any match clears the run.
    always_comb begin
        w_door_next = r_door_open;
        for (int i = 0; i < N_DOORS; i++) begin
            w_deb_next[i] = '0;
            if (sPrta[i] != r_door_open[i]) begin
                if (r_deb_cnt[i] == DEB_LAST) begin
                    w_door_next[i] = ~r_door_open[i];
                end else begin
                    w_deb_next[i] = r_deb_cnt[i] + DW'(1);
                end
            end
        end
    end

    assign w_door_rise = |(r_door_open & ~r_door_prev);
    assign w_ign_rise  = sIgn & ~r_ign_q;
    assign w_any_rise  = w_door_rise | w_ign_rise;

    always_comb begin
        w_state_next    = r_state;
        w_grace_next    = r_grace;
        w_siren_next    = r_siren;
        w_arm_fail_next = 1'b0;
        if (sDisarm) begin
            w_state_next = ST_DISARMED;
            w_grace_next = '0;
            w_siren_next = '0;
        end else begin
            unique case (r_state)
                ST_DISARMED: begin
                    if (sArm && !sIgn) begin
                        w_state_next = ST_ARMING;
                        w_grace_next = GRACE_LD;
                    end
                end
                ST_ARMING: begin
                    if (sIgn) begin
                        w_state_next    = ST_DISARMED;
                        w_grace_next    = '0;
                        w_arm_fail_next = 1'b1;
                    end else if (r_grace <= GW'(1)) begin
                        w_grace_next = '0;
                        if (|r_door_open) begin
                            w_state_next    = ST_DISARMED;
                            w_arm_fail_next = 1'b1;
                        end else begin
                            w_state_next = ST_ARMED;
                        end
                    end else begin
                        w_grace_next = r_grace - GW'(1);
                    end
                end
                ST_ARMED: begin
                    if (w_any_rise) begin
                        w_state_next = ST_TRIGGERED;
                        w_siren_next = SIREN_LD;
                    end
                end
                ST_TRIGGERED: begin
                    // A fresh rise extends the siren even on its final cycle.
                    if (w_any_rise) begin
                        w_siren_next = SIREN_LD;
                    end else if (r_siren <= SW'(1)) begin
                        w_state_next = ST_ARMED;
                        w_siren_next = '0;
                    end else begin
                        w_siren_next = r_siren - SW'(1);
                    end
                end
                default: w_state_next = ST_DISARMED;
            endcase
        end
        w_alarm_next = (w_state_next == ST_TRIGGERED);
    end

    always_ff @(posedge sClk or negedge sRst_n) begin
        if (!sRst_n) begin
            r_state      <= ST_DISARMED;
            r_grace      <= '0;
            r_siren      <= '0;
            r_alarm      <= 1'b0;
            r_arm_fail   <= 1'b0;
            r_light_warn <= 1'b0;
            r_ign_q      <= 1'b0;
            r_door_open  <= '0;
            r_door_prev  <= '0;
            for (int i = 0; i < N_DOORS; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            r_state      <= w_state_next;
            r_grace      <= w_grace_next;
            r_siren      <= w_siren_next;
            r_alarm      <= w_alarm_next;
            r_arm_fail   <= w_arm_fail_next;
            r_light_warn <= sLuz & (|r_door_open) & ~sIgn;
            r_ign_q      <= sIgn;
            r_door_prev  <= r_door_open;
            r_door_open  <= w_door_next;
            for (int i = 0; i < N_DOORS; i++) begin
                r_deb_cnt[i] <= w_deb_next[i];
            end
        end
    end

    assign sState     = r_state;
    assign sAlarm     = r_alarm;
    assign sArmFail   = r_arm_fail;
    assign sLightWarn = r_light_warn;
    assign sDoorOpen  = r_door_open;

endmodule

// File: tb/tb_car_alarm_ctrl.sv
// tb/tb_car_alarm_ctrl.sv - directed and randomized checks of car_alarm_ctrl against a
// deadline-based reference model.
module tb_car_alarm_ctrl;

    localparam int N     = 4;
    localparam int DEB   = 4;
    localparam int GRACE = 16;
    localparam int SIREN = 32;

    logic         sClk = 1'b0;
    logic         sRst_n;
    logic         sLuz;
    logic [N-1:0] sPrta;
    logic         sIgn;
    logic         sArm;
    logic         sDisarm;
    logic         sAlarm;
    logic         sLightWarn;
    logic [N-1:0] sDoorOpen;
    logic [1:0]   sState;
    logic         sArmFail;

    car_alarm_ctrl #(
        .N_DOORS     (N),
        .DEB_CYCLES  (DEB),
        .GRACE_CYCLES(GRACE),
        .SIREN_CYCLES(SIREN)
    ) dut (
        .sClk      (sClk),
        .sRst_n    (sRst_n),
        .sLuz      (sLuz),
        .sPrta     (sPrta),
        .sIgn      (sIgn),
        .sArm      (sArm),
        .sDisarm   (sDisarm),
        .sAlarm    (sAlarm),
        .sLightWarn(sLightWarn),
        .sDoorOpen (sDoorOpen),
        .sState    (sState),
        .sArmFail  (sArmFail)
    );

    always #5 sClk = ~sClk;

    int checks   = 0;
    int failures = 0;

    // Reference model: mode 0..3, absolute deadlines in edge counts, raw-sample history.
    int           m_mode;
    int           m_n;
    int           m_deadline;
    int           m_siren_end;
    logic [N-1:0] m_door;
    logic [N-1:0] m_door_prev;
    logic         m_ign_q;
    logic         m_fail;
    logic         m_light;
    logic [N-1:0] hist[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode      = 0;
        m_n         = 0;
        m_deadline  = 0;
        m_siren_end = 0;
        m_door      = '0;
        m_door_prev = '0;
        m_ign_q     = 1'b0;
        m_fail      = 1'b0;
        m_light     = 1'b0;
        hist.delete();
    endtask

    task automatic model_edge();
        logic         rise;
        logic         light_n;
        logic         all_diff;
        logic [N-1:0] nd;
        light_n = sLuz & (|m_door) & ~sIgn;
        rise    = (|(m_door & ~m_door_prev)) | (sIgn & ~m_ign_q);
        m_fail  = 1'b0;
        if (sDisarm) begin
            m_mode = 0;
        end else begin
            case (m_mode)
                0: if (sArm && !sIgn) begin
                    m_mode     = 1;
                    m_deadline = m_n + GRACE;
                end
                1: if (sIgn) begin
                    m_mode = 0;
                    m_fail = 1'b1;
                end else if (m_n >= m_deadline) begin
                    if (|m_door) begin
                        m_mode = 0;
                        m_fail = 1'b1;
                    end else begin
                        m_mode = 2;
                    end
                end
                2: if (rise) begin
                    m_mode      = 3;
                    m_siren_end = m_n + SIREN;
                end
                default: if (rise) begin
                    m_siren_end = m_n + SIREN;
                end else if (m_n >= m_siren_end) begin
                    m_mode = 2;
                end
            endcase
        end
        hist.push_back(sPrta);
        if (hist.size() > DEB) void'(hist.pop_front());
        nd = m_door;
        if (hist.size() == DEB) begin
            for (int i = 0; i < N; i++) begin
                all_diff = 1'b1;
                for (int j = 0; j < DEB; j++) begin
                    if (hist[j][i] == m_door[i]) all_diff = 1'b0;
                end
                if (all_diff) nd[i] = ~m_door[i];
            end
        end
        m_door_prev = m_door;
        m_door      = nd;
        m_ign_q     = sIgn;
        m_light     = light_n;
        m_n++;
    endtask

    task automatic step();
        @(posedge sClk);
        model_edge();
        #1;
        chk("state",      32'(sState),     32'(m_mode));
        chk("alarm",      32'(sAlarm),     32'(m_mode == 3));
        chk("arm_fail",   32'(sArmFail),   32'(m_fail));
        chk("light_warn", 32'(sLightWarn), 32'(m_light));
        chk("door_open",  32'(sDoorOpen),  32'(m_door));
        sArm    = 1'b0;
        sDisarm = 1'b0;
    endtask

    initial begin
        int cnt;
        sRst_n  = 1'b0;
        sLuz    = 1'b0;
        sPrta   = 4'b0010;
        sIgn    = 1'b0;
        sArm    = 1'b0;
        sDisarm = 1'b0;
        model_reset();
        #12;
        chk("rst_state",  32'(sState),     32'd0);
        chk("rst_alarm",  32'(sAlarm),     32'd0);
        chk("rst_door",   32'(sDoorOpen),  32'd0);
        chk("rst_lw",     32'(sLightWarn), 32'd0);
        chk("rst_fail",   32'(sArmFail),   32'd0);
        @(negedge sClk);
        sRst_n = 1'b1;

        // Door already open at release shows up only after the debounce window.
        repeat (3) step();
        chk("rel_door_early", 32'(sDoorOpen), 32'd0);
        step();
        chk("rel_door_late", 32'(sDoorOpen), 32'b0010);
        chk("rel_no_trigger", 32'(sState), 32'd0);
        sPrta = '0;
        repeat (5) step();

        // Debounce: 3-cycle glitch ignored, 4-cycle hold accepted.
        sPrta[2] = 1'b1;
        repeat (3) step();
        sPrta[2] = 1'b0;
        repeat (3) step();
        chk("glitch3", 32'(sDoorOpen), 32'd0);
        sPrta[2] = 1'b1;
        repeat (3) step();
        chk("hold3", 32'(sDoorOpen), 32'd0);
        step();
        chk("hold4", 32'(sDoorOpen), 32'b0100);
        sPrta = '0;
        repeat (5) step();

        // Light warning follows the debounced door by one cycle.
        sLuz     = 1'b1;
        sPrta[0] = 1'b1;
        repeat (4) step();
        chk("lw_at_deb", 32'(sLightWarn), 32'd0);
        step();
        chk("lw_on", 32'(sLightWarn), 32'd1);
        sIgn = 1'b1;
        step();
        chk("lw_ign_off", 32'(sLightWarn), 32'd0);
        sIgn = 1'b0;
        sLuz = 1'b0;
        step();

        // Arm with door 0 open: 16 cycles of ARMING then abort.
        sArm = 1'b1;
        step();
        cnt = 1;
        for (int k = 0; k < 100; k++) begin
            step();
            if (sState == 2'b01) cnt++;
            else break;
        end
        chk("armfail_len", 32'(cnt), 32'd16);
        chk("armfail_state", 32'(sState), 32'd0);
        chk("armfail_pulse", 32'(sArmFail), 32'd1);
        step();
        chk("armfail_one_cycle", 32'(sArmFail), 32'd0);
        sPrta = '0;
        repeat (5) step();

        // Arm with doors closed.
        sArm = 1'b1;
        step();
        cnt = 1;
        for (int k = 0; k < 100; k++) begin
            step();
            if (sState == 2'b01) cnt++;
            else break;
        end
        chk("arming_len", 32'(cnt), 32'd16);
        chk("armed_state", 32'(sState), 32'b10);

        // Door 1 trigger: debounce + 1 latency, 32-cycle siren, no retrigger while still open.
        sPrta[1] = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            cnt++;
            if (sAlarm) break;
        end
        chk("trig_latency", 32'(cnt), 32'd5);
        cnt = 1;
        for (int k = 0; k < 100; k++) begin
            step();
            if (sAlarm) cnt++;
            else break;
        end
        chk("siren_len", 32'(cnt), 32'd32);
        chk("siren_end_state", 32'(sState), 32'b10);
        chk("siren_end_door", 32'(sDoorOpen), 32'b0010);
        repeat (3) step();

        // Ignition trigger, then door 3 rise reloads at cycle 20.
        sIgn = 1'b1;
        step();
        chk("ign_trigger", 32'(sAlarm), 32'd1);
        sIgn = 1'b0;
        cnt = 1;
        for (int k = 0; k < 200; k++) begin
            if (cnt == 16) sPrta[3] = 1'b1;
            step();
            if (sAlarm) cnt++;
            else break;
        end
        chk("retrigger_len", 32'(cnt), 32'd52);

        // Arm and disarm together while triggered: disarm wins.
        sIgn = 1'b1;
        step();
        sIgn = 1'b0;
        repeat (3) step();
        chk("pre_prio_alarm", 32'(sAlarm), 32'd1);
        sArm    = 1'b1;
        sDisarm = 1'b1;
        step();
        chk("prio_state", 32'(sState), 32'd0);
        chk("prio_alarm", 32'(sAlarm), 32'd0);

        // Asynchronous reset while triggered.
        sPrta = '0;
        repeat (5) step();
        sArm = 1'b1;
        step();
        repeat (16) step();
        chk("rearmed", 32'(sState), 32'b10);
        sIgn = 1'b1;
        step();
        sIgn = 1'b0;
        repeat (4) step();
        chk("pre_rst_alarm", 32'(sAlarm), 32'd1);
        #1;
        sRst_n = 1'b0;
        #1;
        chk("async_rst_alarm", 32'(sAlarm), 32'd0);
        chk("async_rst_state", 32'(sState), 32'd0);
        model_reset();
        @(negedge sClk);
        sRst_n = 1'b1;

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            int d;
            d = int'($urandom_range(0, N - 1));
            if ($urandom_range(0, 9) == 0) sPrta[d] = ~sPrta[d];
            if ($urandom_range(0, 39) == 0) sIgn = ~sIgn;
            if ($urandom_range(0, 29) == 0) sLuz = ~sLuz;
            sArm    = ($urandom_range(0, 14) == 0);
            sDisarm = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
